// File: rtl/simd_issue_ctrl.sv
// simd_issue_ctrl: issue front end for the 4-lane SIMD core.
// Holds a host-accessible vector register file. It accepts one instruction
// per valid/ready handshake, presents the snapshotted source vectors to the
// core, and writes the core's registered result back to the destination.
// Optional build macro: SIMD_ILLEGAL_OP_TRAP_EN. When it is defined,
// opcodes above 3'b100 are not issued and raise a sticky err flag.
module simd_issue_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4,
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [2:0]             instr_op,
  input  logic [AW-1:0]          instr_dst,
  input  logic [AW-1:0]          instr_srca,
  input  logic [AW-1:0]          instr_srcb,
  input  logic                   rf_we,
  input  logic [AW-1:0]          rf_waddr,
  input  logic [LANES*WIDTH-1:0] rf_wdata,
  input  logic [AW-1:0]          rf_raddr,
  output logic [LANES*WIDTH-1:0] rf_rdata,
  output logic [2:0]             core_opcode,
  output logic [LANES*WIDTH-1:0] core_a,
  output logic [LANES*WIDTH-1:0] core_b,
  input  logic [LANES*WIDTH-1:0] core_r,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned VW = LANES * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE
  } state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   vrf_q [NREGS];
  logic [2:0]      opcode_q;
  logic [VW-1:0]   a_q, b_q;
  logic [AW-1:0]   dst_q;
  logic            drop_q;
  logic            done_q;
  logic            accept;
  logic            op_illegal;
  logic            drop_instr;
  logic            wb_en;

  assign accept     = (state_q == S_IDLE) && instr_valid;
  assign op_illegal = (instr_op > 3'b100);

`ifdef SIMD_ILLEGAL_OP_TRAP_EN
  assign drop_instr = op_illegal;
`else
  assign drop_instr = 1'b0;
`endif

  // A dropped instruction still walks the pipeline but never writes back.
  assign wb_en = (state_q == S_CAPTURE) && !drop_q;

  // Next-state logic: fixed three-cycle walk per accepted instruction.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (instr_valid) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Snapshot operands at accept; core inputs hold between instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dst_q    <= '0;
      drop_q   <= 1'b0;
    end else if (accept) begin
      dst_q  <= instr_dst;
      drop_q <= drop_instr;
      if (!drop_instr) begin
        opcode_q <= instr_op;
        a_q      <= vrf_q[instr_srca];
        b_q      <= vrf_q[instr_srcb];
      end
    end
  end

  // Register file: host write first so a same-address writeback overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) vrf_q[i] <= '0;
    end else begin
      if (rf_we) vrf_q[rf_waddr] <= rf_wdata;
      if (wb_en) vrf_q[dst_q]    <= core_r;
    end
  end

  // Completion pulse in the cycle after the CAPTURE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= (state_q == S_CAPTURE);
  end

`ifdef SIMD_ILLEGAL_OP_TRAP_EN
  logic err_q;

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      err_q <= 1'b0;
    else if (accept && op_illegal) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign core_opcode = opcode_q;
  assign core_a      = a_q;
  assign core_b      = b_q;
  assign rf_rdata    = vrf_q[rf_raddr];

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Directed bench for simd_issue_ctrl with a behavioural one-cycle SIMD core.
module tb_simd_issue_ctrl;

  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam int VW    = LANES * WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid, instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_dst, instr_srca, instr_srcb;
  logic          rf_we;
  logic [AW-1:0] rf_waddr, rf_raddr;
  logic [VW-1:0] rf_wdata, rf_rdata;
  logic [2:0]    core_opcode;
  logic [VW-1:0] core_a, core_b;
  logic [VW-1:0] core_r = '0;
  logic          busy, done, err;

  int errors = 0;
  int checks = 0;

  simd_issue_ctrl #(.WIDTH(WIDTH), .LANES(LANES), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_dst(instr_dst), .instr_srca(instr_srca), .instr_srcb(instr_srcb),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .core_opcode(core_opcode), .core_a(core_a), .core_b(core_b), .core_r(core_r),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] core_fn(logic [2:0] op, logic [VW-1:0] a, logic [VW-1:0] b);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      case (op)
        3'b000:  r[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] + b[i*WIDTH +: WIDTH];
        3'b001:  r[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] - b[i*WIDTH +: WIDTH];
        3'b010:  r[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] & b[i*WIDTH +: WIDTH];
        3'b011:  r[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] | b[i*WIDTH +: WIDTH];
        3'b100:  r[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] * b[i*WIDTH +: WIDTH];
        default: r[i*WIDTH +: WIDTH] = 32'hDEADBEEF;
      endcase
    end
    return r;
  endfunction

  // Core model: R registered one cycle after A/B/opcode.
  always @(posedge clk) core_r <= core_fn(core_opcode, core_a, core_b);

  function automatic logic [VW-1:0] v4(logic [31:0] l0, logic [31:0] l1, logic [31:0] l2, logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [VW-1:0] splat(logic [31:0] x);
    return {x, x, x, x};
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rcheck(input string tag, input logic [AW-1:0] addr, input logic [VW-1:0] exp);
    rf_raddr = addr;
    #1;
    chk(tag, rf_rdata, exp);
  endtask

  task automatic hwrite(input logic [AW-1:0] addr, input logic [VW-1:0] data);
    @(negedge clk);
    rf_we = 1'b1; rf_waddr = addr; rf_wdata = data;
    @(negedge clk);
    rf_we = 1'b0;
  endtask

  // Returns at the negedge inside ISSUE.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] dst,
                       input logic [AW-1:0] sa, input logic [AW-1:0] sb);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_dst = dst; instr_srca = sa; instr_srcb = sb;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("accepted_busy", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_dst = '0;
    instr_srca = '0; instr_srcb = '0; rf_we = 1'b0; rf_waddr = '0;
    rf_wdata = '0; rf_raddr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int r = 0; r < NREGS; r++) rcheck("reset_vrf", AW'(r), '0);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_ready", instr_ready, 1);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_core_a", core_a, '0);
    chk("reset_core_op", core_opcode, 0);

    // ADD with cycle-by-cycle handshake
    hwrite(1, v4(1, 2, 3, 4));
    hwrite(2, v4(10, 20, 30, 40));
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'b000; instr_dst = 3; instr_srca = 1; instr_srcb = 2;
    chk("add_ready_pre", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("add_issue_ready", instr_ready, 0);
    chk("add_issue_busy", busy, 1);
    chk("add_issue_done", done, 0);
    chk("add_core_a", core_a, v4(1, 2, 3, 4));
    chk("add_core_b", core_b, v4(10, 20, 30, 40));
    chk("add_core_op", core_opcode, 3'b000);
    @(negedge clk);
    chk("add_capture_ready", instr_ready, 0);
    chk("add_capture_done", done, 0);
    @(negedge clk);
    chk("add_done", done, 1);
    chk("add_done_ready", instr_ready, 1);
    chk("add_done_busy", busy, 0);
    rcheck("add_r3", 3, v4(11, 22, 33, 44));
    @(negedge clk);
    chk("add_done_width", done, 0);

    // SUB wrap
    hwrite(1, v4(0, 5, 7, 9));
    hwrite(2, v4(1, 2, 3, 4));
    issue(3'b001, 3, 1, 2);
    wait_done("sub_done");
    rcheck("sub_r3", 3, v4(32'hFFFFFFFF, 3, 4, 5));

    // MUL low bits, then AND
    hwrite(1, v4(32'h10000, 3, 32'hFFFFFFFF, 7));
    hwrite(2, v4(32'h10000, 5, 2, 0));
    issue(3'b100, 5, 1, 2);
    wait_done("mul_done");
    rcheck("mul_r5", 5, v4(0, 15, 32'hFFFFFFFE, 0));
    issue(3'b010, 6, 1, 2);
    wait_done("and_done");
    rcheck("and_r6", 6, v4(32'h10000, 1, 2, 0));

    // Back-to-back with host write to a source on the accept edge
    hwrite(1, v4(1, 2, 3, 4));
    hwrite(2, v4(10, 20, 30, 40));
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'b000; instr_dst = 1; instr_srca = 1; instr_srcb = 2;
    rf_we = 1'b1; rf_waddr = 1; rf_wdata = splat(100);
    @(negedge clk);
    rf_we = 1'b0;
    instr_op = 3'b011; instr_dst = 4; instr_srca = 1; instr_srcb = 1;
    chk("b2b_issue_ready", instr_ready, 0);
    chk("b2b_core_a_old", core_a, v4(1, 2, 3, 4));
    @(negedge clk);
    chk("b2b_capture_ready", instr_ready, 0);
    @(negedge clk);
    chk("b2b_first_done", done, 1);
    chk("b2b_ready_in_done", instr_ready, 1);
    rcheck("b2b_r1", 1, v4(11, 22, 33, 44));
    @(negedge clk);
    instr_valid = 1'b0;
    chk("b2b_second_busy", busy, 1);
    chk("b2b_second_op", core_opcode, 3'b011);
    chk("b2b_second_a", core_a, v4(11, 22, 33, 44));
    wait_done("b2b_second_done");
    rcheck("b2b_r4", 4, v4(11, 22, 33, 44));

    // Writeback collides with host write to the same register
    issue(3'b000, 3, 1, 2);
    @(negedge clk);
    rf_we = 1'b1; rf_waddr = 3; rf_wdata = splat(5);
    @(negedge clk);
    rf_we = 1'b0;
    chk("coll_done", done, 1);
    rcheck("coll_r3", 3, v4(21, 42, 63, 84));

    // Writeback alongside host write to a different register
    issue(3'b000, 7, 1, 2);
    @(negedge clk);
    rf_we = 1'b1; rf_waddr = 0; rf_wdata = splat(5);
    @(negedge clk);
    rf_we = 1'b0;
    rcheck("diff_r7", 7, v4(21, 42, 63, 84));
    rcheck("diff_r0", 0, splat(5));

    // Illegal opcode 111
    issue(3'b111, 6, 2, 1);
    wait_done("ill_done");
`ifdef SIMD_ILLEGAL_OP_TRAP_EN
    rcheck("ill_r6_kept", 6, v4(32'h10000, 1, 2, 0));
    chk("ill_err", err, 1);
    chk("ill_core_op_held", core_opcode, 3'b000);
    chk("ill_core_a_held", core_a, v4(11, 22, 33, 44));
    issue(3'b000, 5, 1, 2);
    wait_done("ill_after_done");
    chk("ill_err_sticky", err, 1);
    rcheck("ill_after_r5", 5, v4(21, 42, 63, 84));
`else
    rcheck("ill_r6_dead", 6, splat(32'hDEADBEEF));
    chk("ill_err", err, 0);
    chk("ill_core_op", core_opcode, 3'b111);
`endif

    // Reset during ISSUE aborts the instruction
    issue(3'b000, 7, 1, 2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    rcheck("rst_mid_r7", 7, '0);
    chk("rst_mid_done_after", done, 0);
    @(negedge clk);
    chk("rst_mid_done_later", done, 0);
    chk("rst_mid_ready", instr_ready, 1);
    chk("rst_mid_err", err, 0);
    rcheck("rst_mid_r1", 1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
